// File: rtl/buffer_64bit_pkg.sv
// buffer_64bit_pkg: shared access-mode encoding and lane geometry for the 64-bit buffer.
package buffer_64bit_pkg;
    typedef enum logic {
        BYTE_MODE = 1'b0,
        WORD_MODE = 1'b1
    } mode_e;
    localparam int Lanes = 8;
endpackage

// File: rtl/buffer_lane.sv
// buffer_lane: one byte lane of storage with synchronous clear and a combinational read port.
module buffer_lane #(
    parameter int Depth = 16,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AddrW-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem [Depth];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) mem[i] <= 8'h00;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end
    // Read sees pre-edge contents, so a same-cycle write never leaks into the read.
    assign rdata = mem[addr];
endmodule

// File: rtl/buffer_64bit.sv
// buffer_64bit: byte/word addressable little-endian buffer built from eight byte lanes.
module buffer_64bit
    import buffer_64bit_pkg::*;
#(
    parameter int BuffDepth = 128,
    localparam int ByteAddrW = $clog2(BuffDepth),
    localparam int WordAddrW = $clog2(BuffDepth / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 addr_mode,
    input  logic [ByteAddrW-1:0] byte_addr,
    input  logic [WordAddrW-1:0] word_addr,
    input  logic [7:0]           byte_in,
    input  logic [63:0]          word_in,
    output logic [7:0]           byte_out,
    output logic [63:0]          word_out
);
    logic                 word_mode;
    logic [WordAddrW-1:0] row;
    logic [2:0]           lane_sel;
    logic [Lanes-1:0]     lane_we;
    logic [63:0]          rd_word;

    assign word_mode = mode_e'(addr_mode) == WORD_MODE;
    assign row       = word_mode ? word_addr : byte_addr[ByteAddrW-1:3];
    assign lane_sel  = byte_addr[2:0];

    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        assign lane_we[g] = write_en & (word_mode | (lane_sel == 3'(g)));
        buffer_lane #(.Depth(BuffDepth / 8)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we[g]),
            .addr  (row),
            .wdata (word_mode ? word_in[8*g +: 8] : byte_in),
            .rdata (rd_word[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_out <= 8'h00;
            word_out <= 64'h0;
        end else if (read_en) begin
            if (word_mode) word_out <= rd_word;
            else byte_out <= rd_word[8*lane_sel +: 8];
        end
    end
endmodule

// File: tb/tb_buffer_64bit.sv
// tb_buffer_64bit: directed and randomized checks of buffer_64bit against a byte-array model.
module tb_buffer_64bit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic        addr_mode = 1'b0;
    logic [6:0]  byte_addr = '0;
    logic [3:0]  word_addr = '0;
    logic [7:0]  byte_in = '0;
    logic [63:0] word_in = '0;
    logic [7:0]  byte_out;
    logic [63:0] word_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [128];
    logic [7:0]  exp_byte;
    logic [63:0] exp_word;

    buffer_64bit dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .read_en   (read_en),
        .addr_mode (addr_mode),
        .byte_addr (byte_addr),
        .word_addr (word_addr),
        .byte_in   (byte_in),
        .word_in   (word_in),
        .byte_out  (byte_out),
        .word_out  (word_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_word(input int w);
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[8*w + k];
        return v;
    endfunction

    task automatic apply(input logic r, input logic we, input logic re, input logic md,
                         input logic [6:0] ba, input logic [3:0] wa,
                         input logic [7:0] bi, input logic [63:0] wi);
        rst = r; write_en = we; read_en = re; addr_mode = md;
        byte_addr = ba; word_addr = wa; byte_in = bi; word_in = wi;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'h00;
            exp_byte = 8'h00;
            exp_word = 64'h0;
        end else begin
            if (re) begin
                if (md) exp_word = model_word(int'(wa));
                else exp_byte = mem[ba];
            end
            if (we) begin
                if (md) for (int k = 0; k < 8; k++) mem[8*int'(wa) + k] = wi[8*k +: 8];
                else mem[ba] = bi;
            end
        end
        rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 7'd0, 4'd0, 8'h00, 64'h0);
        checks++;
        if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", byte_out); end
        checks++;
        if (word_out !== 64'h0) begin errors++; $display("FAIL reset_word got %h want 0", word_out); end
        apply(0, 0, 1, 1, 7'd0, 4'd5, 8'h00, 64'h0);
        checks++;
        if (word_out !== 64'h0) begin errors++; $display("FAIL reset_read5 got %h want 0", word_out); end
    endtask

    task automatic test_word_rw();
        apply(0, 1, 0, 1, 7'd0, 4'd3, 8'h00, 64'h0123456789ABCDEF);
        apply(0, 0, 1, 1, 7'd0, 4'd3, 8'h00, 64'h0);
        checks++;
        if (word_out !== 64'h0123456789ABCDEF)
            begin errors++; $display("FAIL word_rw got %h want 0123456789abcdef", word_out); end
    endtask

    task automatic test_cross_mode();
        apply(0, 0, 1, 0, 7'd24, 4'd0, 8'h00, 64'h0);
        checks++;
        if (byte_out !== 8'hEF) begin errors++; $display("FAIL cross_b24 got %h want ef", byte_out); end
        checks++;
        if (word_out !== 64'h0123456789ABCDEF)
            begin errors++; $display("FAIL cross_word_hold got %h want 0123456789abcdef", word_out); end
        apply(0, 0, 1, 0, 7'd31, 4'd0, 8'h00, 64'h0);
        checks++;
        if (byte_out !== 8'h01) begin errors++; $display("FAIL cross_b31 got %h want 01", byte_out); end
    endtask

    task automatic test_byte_merge();
        apply(0, 1, 0, 0, 7'd26, 4'd9, 8'h5A, 64'h0);
        apply(0, 0, 1, 1, 7'd0, 4'd3, 8'h00, 64'h0);
        checks++;
        if (word_out !== 64'h01234567895ACDEF)
            begin errors++; $display("FAIL byte_merge got %h want 01234567895acdef", word_out); end
        checks++;
        if (byte_out !== 8'h01) begin errors++; $display("FAIL merge_byte_hold got %h want 01", byte_out); end
    endtask

    task automatic test_back_to_back();
        apply(0, 1, 1, 1, 7'd0, 4'd3, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++;
        if (word_out !== 64'h01234567895ACDEF)
            begin errors++; $display("FAIL rbw_old got %h want 01234567895acdef", word_out); end
        apply(0, 0, 1, 1, 7'd0, 4'd3, 8'h00, 64'h0);
        checks++;
        if (word_out !== 64'hFFFF_FFFF_FFFF_FFFF)
            begin errors++; $display("FAIL rbw_new got %h want all ones", word_out); end
        apply(0, 1, 1, 0, 7'd30, 4'd0, 8'h77, 64'h0);
        checks++;
        if (byte_out !== 8'hFF) begin errors++; $display("FAIL rbw_byte_old got %h want ff", byte_out); end
    endtask

    task automatic test_hold_reset_priority();
        logic [7:0]  hb;
        logic [63:0] hw;
        hb = byte_out;
        hw = word_out;
        for (int i = 0; i < 4; i++)
            apply(0, 1, 0, 1'($urandom), 7'($urandom), 4'($urandom), 8'($urandom), {$urandom, $urandom});
        checks++;
        if (byte_out !== hb || word_out !== hw)
            begin errors++; $display("FAIL hold got %h/%h want %h/%h", byte_out, word_out, hb, hw); end
        apply(1, 1, 1, 1, 7'd0, 4'd7, 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
        checks++;
        if (word_out !== 64'h0 || byte_out !== 8'h00)
            begin errors++; $display("FAIL rst_prio_out got %h/%h want 0/0", byte_out, word_out); end
        apply(0, 0, 1, 1, 7'd0, 4'd7, 8'h00, 64'h0);
        checks++;
        if (word_out !== 64'h0) begin errors++; $display("FAIL rst_prio_drop got %h want 0", word_out); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  7'($urandom), 4'($urandom), 8'($urandom), {$urandom, $urandom});
            checks++;
            if (byte_out !== exp_byte || word_out !== exp_word) begin
                errors++;
                $display("FAIL random_%0d got %h/%h want %h/%h", n, byte_out, word_out, exp_byte, exp_word);
            end
        end
        for (int w = 0; w < 16; w++) begin
            apply(0, 0, 1, 1, 7'd0, 4'(w), 8'h00, 64'h0);
            checks++;
            if (word_out !== exp_word)
                begin errors++; $display("FAIL sweep_w%0d got %h want %h", w, word_out, exp_word); end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_word_rw();
        test_cross_mode();
        test_byte_merge();
        test_back_to_back();
        test_hold_reset_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/buffer_64bit.md
BUFFER_64BIT -- requirements
Module: buffer_64bit

Interface
REQ-001 The block SHALL have parameter BuffDepth, default 128, giving total buffer capacity in bytes; it must be a power of two and at least 8.
REQ-002 The block SHALL derive the local constant ByteAddrW = clog2(BuffDepth), default 7.
REQ-003 The block SHALL derive the local constant WordAddrW = clog2(BuffDepth/8), default 4.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 write_en  input  1  write strobe, sampled on the rising clk edge.
REQ-008 read_en  input  1  read strobe, sampled on the rising clk edge.
REQ-009 addr_mode  input  1  access mode: 0 = byte access, 1 = 64-bit word access.
REQ-010 byte_addr  input  ByteAddrW  byte address, used when addr_mode=0.
REQ-011 word_addr  input  WordAddrW  word address, used when addr_mode=1.
REQ-012 byte_in  input  8  byte write data.
REQ-013 word_in  input  64  word write data.
REQ-014 byte_out  output  8  registered byte read data.
REQ-015 word_out  output  64  registered word read data.

Function
REQ-016 Storage SHALL be BuffDepth bytes; word w SHALL occupy bytes 8w..8w+7, little-endian, with byte 8w+k at word bits [8k+7:8k].
REQ-017 A byte write (write_en=1, addr_mode=0) SHALL store byte_in at byte_addr on the clock edge and leave all other bytes unchanged.
REQ-018 A word write (write_en=1, addr_mode=1) SHALL store all 8 bytes of word_in at word_addr in the same edge.
REQ-019 A byte read (read_en=1, addr_mode=0) SHALL load byte_out with the addressed byte one cycle later; word_out SHALL hold its value.
REQ-020 A word read (read_en=1, addr_mode=1) SHALL load word_out with the addressed word one cycle later; byte_out SHALL hold its value.
REQ-021 When read_en=0, both outputs SHALL hold their last values.
REQ-022 When write_en=1 and read_en=1 in the same cycle at an overlapping address, the read SHALL return the pre-write (old) data, i.e. read-before-write.
REQ-023 Byte and word views SHALL be coherent: data written in one mode SHALL be readable in the other mode according to REQ-016.
REQ-024 Addresses SHALL be used unmodified; the full address range is valid, so no out-of-range case exists.
REQ-025 In each mode, the address input for the other mode SHALL be ignored.

Reset
REQ-026 When rst=1 at a clock edge, byte_out SHALL become 0x00, word_out SHALL become 0, and every storage byte SHALL become 0x00.
REQ-027 Reset SHALL take priority over write_en and read_en in the same cycle.
REQ-028 Power-up contents before the first reset are undefined.

Structure
REQ-029 No shared package is required; ByteAddrW and WordAddrW SHALL be local constants derived from BuffDepth.
REQ-030 The design SHALL be a single module; an optional byte-lane storage sub-module named buffer_lane (8 lanes, each BuffDepth/8 bytes, with per-lane write enable) is acceptable.

Verification
REQ-031 Reset: assert rst for 1 cycle -> byte_out=0x00, word_out=0, and a word read of address 5 returns 0.
REQ-032 Word write then word read: word_in=0x0123456789ABCDEF written at word_addr=3, then word read of word_addr=3 -> word_out=0x0123456789ABCDEF one cycle after read_en.
REQ-033 Cross-mode coherence: after REQ-032, byte read at byte_addr=24 -> 0xEF, and byte read at byte_addr=31 -> 0x01.
REQ-034 Byte write merge: byte_in=0x5A written at byte_addr=26, then word read of word_addr=3 -> 0x0123456789 5A CDEF, i.e. 0x01234567895ACDEF.
REQ-035 Simultaneous read and write: word write of 0xFFFF...FF and word read both at word_addr=3 in one cycle -> word_out=0x01234567895ACDEF; the next word read of word_addr=3 -> all ones.
REQ-036 Hold and reset priority: with read_en=0 the outputs stay stable; rst=1 together with write_en=1 -> the write is dropped and the addressed data reads 0.
